decode_hazard_stage: RTL

- Parametrised successor decode stage for the Beta pipeline.
- Owns the decode pipeline register (PC, IR, valid) and an internal register file with write-through.
- Provides a generalised bypass/interlock network over NUM_BYP downstream stages, with configurable load-data readiness.
- Sits between fetch and execute; drives operand A/B data, stall back to fetch, and a bubble or the instruction forward.

---
 rtl/decode_hazard_stage.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/decode_hazard_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_hazard_stage
// Brief    : Beta decode stage with register file, bypass network and load
//            interlock. Optional stall counter enabled by DEC_STALL_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module decode_hazard_stage #(
    parameter int XLEN       = 32,
    parameter int NREGS      = 32,
    parameter int NUM_BYP    = 3,
    parameter int LOAD_READY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [XLEN-1:0]         pc_in,
    input  logic [31:0]             ir_in,
    input  logic                    valid_in,
    input  logic                    flush,
    input  logic [NUM_BYP*5-1:0]    dst_addr,
    input  logic [NUM_BYP-1:0]      dst_we,
    input  logic [NUM_BYP-1:0]      dst_ld,
    input  logic [NUM_BYP*XLEN-1:0] byp_data,
    input  logic                    rf_we,
    input  logic [4:0]              rf_wa,
    input  logic [XLEN-1:0]         rf_wd,
    output logic [XLEN-1:0]         a_data,
    output logic [XLEN-1:0]         b_data,
    output logic [XLEN-1:0]         pc_out,
    output logic [31:0]             ir_out,
    output logic                    valid_out,
    output logic                    stall,
    output logic [31:0]             stall_cnt
);

    localparam logic [31:0] c_NOP    = 32'h83FF_F800;
    localparam logic [5:0]  c_OP_LDR = 6'b011111;
    localparam logic [5:0]  c_OP_ST  = 6'b011001;

    typedef struct packed {
        logic            hazard;
        logic [XLEN-1:0] data;
    } operand_t;

    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_ir;
    logic            r_valid;
    logic [XLEN-1:0] r_rf [NREGS];

    logic [5:0]      w_op;
    logic [4:0]      w_ra;
    logic [4:0]      w_rb;
    logic            w_uses_a;
    logic            w_uses_b;
    logic [XLEN-1:0] w_rf_a;
    logic [XLEN-1:0] w_rf_b;
    operand_t        w_opa;
    operand_t        w_opb;
    logic            w_stall;

    // Nearest stage wins: scan from farthest to nearest so the last hit sticks.
    function automatic operand_t f_resolve(
        input logic [4:0]              s,
        input logic [NUM_BYP*5-1:0]    addr,
        input logic [NUM_BYP-1:0]      we,
        input logic [NUM_BYP-1:0]      ld,
        input logic [NUM_BYP*XLEN-1:0] byp,
        input logic                    wb_we,
        input logic [4:0]              wb_wa,
        input logic [XLEN-1:0]         wb_wd,
        input logic [XLEN-1:0]         rf_rd
    );
        operand_t res;
        logic     hit;
        res.hazard = 1'b0;
        res.data   = (wb_we && (wb_wa == s)) ? wb_wd : rf_rd;
        hit        = 1'b0;
        for (int k = NUM_BYP - 1; k >= 0; k--) begin
            if (we[k] && (addr[5*k +: 5] == s)) begin
                hit        = 1'b1;
                res.hazard = ld[k] && (k < LOAD_READY);
                res.data   = byp[XLEN*k +: XLEN];
            end
        end
        if (int'(s) == NREGS - 1) begin
            res.hazard = 1'b0;
            res.data   = '0;
        end
        return res;
    endfunction

    assign w_op     = r_ir[31:26];
    assign w_ra     = r_ir[20:16];
    assign w_rb     = (w_op == c_OP_ST) ? r_ir[25:21] : r_ir[15:11];
    assign w_uses_a = r_valid && (w_op != c_OP_LDR);
    assign w_uses_b = r_valid && ((w_op[5:4] == 2'b10) || (w_op == c_OP_ST));

    assign w_rf_a = (int'(w_ra) < NREGS) ? r_rf[w_ra] : '0;
    assign w_rf_b = (int'(w_rb) < NREGS) ? r_rf[w_rb] : '0;

    always_comb begin
        w_opa = f_resolve(w_ra, dst_addr, dst_we, dst_ld, byp_data,
                          rf_we, rf_wa, rf_wd, w_rf_a);
        w_opb = f_resolve(w_rb, dst_addr, dst_we, dst_ld, byp_data,
                          rf_we, rf_wa, rf_wd, w_rf_b);
    end

    // An annulled instruction can never hold up fetch.
    assign w_stall = ((w_uses_a && w_opa.hazard) || (w_uses_b && w_opb.hazard)) && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc    <= '0;
            r_ir    <= c_NOP;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_ir    <= c_NOP;
            r_valid <= 1'b0;
        end else if (!w_stall) begin
            r_pc    <= pc_in;
            r_ir    <= ir_in;
            r_valid <= valid_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_rf[i] <= '0;
            end
        end else if (rf_we && (int'(rf_wa) < NREGS - 1)) begin
            r_rf[rf_wa] <= rf_wd;
        end
    end

    assign a_data    = w_opa.data;
    assign b_data    = w_opb.data;
    assign stall     = w_stall;
    assign valid_out = r_valid && !w_stall;
    assign ir_out    = valid_out ? r_ir : c_NOP;
    assign pc_out    = r_pc;

`ifdef DEC_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire
